// File: rtl/add8_err_monitor.sv
// Error-statistics monitor for 8-bit approximate adders: recomputes the exact sum and
// accumulates EP/MAE/MSE/WCE figures over an N_TARGET-sample run through a 3-stage pipeline.
module add8_err_monitor #(
  parameter int W        = 8,
  parameter int CNT_W    = 17,
  parameter int N_TARGET = 65536
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [W-1:0]           a,
  input  logic [W-1:0]           b,
  input  logic [W:0]             o,
  output logic                   busy,
  output logic                   done,
  output logic [CNT_W-1:0]       n_samples,
  output logic [CNT_W-1:0]       err_count,
  output logic [W+CNT_W:0]       sum_abs,
  output logic [2*W+1+CNT_W:0]   sum_sq,
  output logic [W:0]             wce,
  output logic [W-1:0]           wce_a,
  output logic [W-1:0]           wce_b
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] N_T = CNT_W'(N_TARGET);

  state_t             state;
  logic [CNT_W-1:0]   accepted;
  logic               accept;

  logic               v1, v2, v3;
  logic [W-1:0]       a1, b1, a2, b2, a3, b3;
  logic [W:0]         o1, exact1, abs2, abs3;
  logic [2*W+1:0]     sq3;

  logic [W+1:0]       e_c, neg_e_c;
  logic [W:0]         abs_c;
  logic [2*W+1:0]     sq_c;

  assign in_ready = (state == RUN) && (accepted < N_T);
  assign accept   = in_valid && in_ready;
  assign busy     = (state == RUN);
  assign done     = (state == DONE);

  // e is signed W+2 bits; its magnitude always fits in W+1 bits
  assign e_c     = {1'b0, o1} - {1'b0, exact1};
  assign neg_e_c = -e_c;
  assign abs_c   = e_c[W+1] ? neg_e_c[W:0] : e_c[W:0];
  assign sq_c    = (2*W+2)'(abs2) * (2*W+2)'(abs2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      accepted  <= '0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      v3        <= 1'b0;
      a1        <= '0;
      b1        <= '0;
      o1        <= '0;
      exact1    <= '0;
      a2        <= '0;
      b2        <= '0;
      abs2      <= '0;
      a3        <= '0;
      b3        <= '0;
      abs3      <= '0;
      sq3       <= '0;
      n_samples <= '0;
      err_count <= '0;
      sum_abs   <= '0;
      sum_sq    <= '0;
      wce       <= '0;
      wce_a     <= '0;
      wce_b     <= '0;
    end else begin
      v1 <= accept;
      if (accept) begin
        a1     <= a;
        b1     <= b;
        o1     <= o;
        exact1 <= {1'b0, a} + {1'b0, b};
      end

      v2 <= v1;
      if (v1) begin
        abs2 <= abs_c;
        a2   <= a1;
        b2   <= b1;
      end

      v3 <= v2;
      if (v2) begin
        sq3  <= sq_c;
        abs3 <= abs2;
        a3   <= a2;
        b3   <= b2;
      end

      if (start && state != RUN) begin
        state     <= RUN;
        accepted  <= '0;
        n_samples <= '0;
        err_count <= '0;
        sum_abs   <= '0;
        sum_sq    <= '0;
        wce       <= '0;
        wce_a     <= '0;
        wce_b     <= '0;
      end else begin
        if (accept)
          accepted <= accepted + CNT_W'(1);
        if (v3) begin
          n_samples <= n_samples + CNT_W'(1);
          err_count <= err_count + CNT_W'(abs3 != '0);
          sum_abs   <= sum_abs + (W+1+CNT_W)'(abs3);
          sum_sq    <= sum_sq + (2*W+2+CNT_W)'(sq3);
          // strict compare: ties keep the earliest sample's operands
          if (abs3 > wce) begin
            wce   <= abs3;
            wce_a <= a3;
            wce_b <= b3;
          end
        end
        if (state == RUN && n_samples == N_T)
          state <= DONE;
      end
    end
  end

endmodule

// File: tb/tb_add8_err_monitor.sv
// Directed bench for add8_err_monitor with a short run length; expected statistics are
// hand-computed per vector set.
module tb_add8_err_monitor;

  localparam int W = 8;
  localparam int CNT_W = 17;
  localparam int N = 64;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [W-1:0]         a = '0, b = '0;
  logic [W:0]           o = '0;
  logic                 busy, done;
  logic [CNT_W-1:0]     n_samples, err_count;
  logic [W+CNT_W:0]     sum_abs;
  logic [2*W+1+CNT_W:0] sum_sq;
  logic [W:0]           wce;
  logic [W-1:0]         wce_a, wce_b;

  int total = 0;
  int bad = 0;

  logic [W-1:0] va [N];
  logic [W-1:0] vb [N];
  logic [W:0]   vo [N];

  add8_err_monitor #(.W(W), .CNT_W(CNT_W), .N_TARGET(N)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .o(o), .busy(busy), .done(done), .n_samples(n_samples),
    .err_count(err_count), .sum_abs(sum_abs), .sum_sq(sum_sq), .wce(wce),
    .wce_a(wce_a), .wce_b(wce_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic chk_stats(input string tag, input int n, input int err, input longint sabs,
                           input longint ssq, input int w, input int wa, input int wb);
    chk({tag, ".n"},    64'(n_samples), 64'(n));
    chk({tag, ".err"},  64'(err_count), 64'(err));
    chk({tag, ".sabs"}, 64'(sum_abs),   64'(sabs));
    chk({tag, ".ssq"},  64'(sum_sq),    64'(ssq));
    chk({tag, ".wce"},  64'(wce),       64'(w));
    chk({tag, ".wa"},   64'(wce_a),     64'(wa));
    chk({tag, ".wb"},   64'(wce_b),     64'(wb));
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Feeds va/vb/vo once; optional random gaps and a start pulse while RUN.
  task automatic run_vectors(input string tag, input bit gaps, input int start_at);
    int idx = 0;
    int cyc = 0;
    bit acc;
    do_start();
    chk({tag, ".busy_run"}, 64'(busy), 64'd1);
    while (idx < N && cyc < 1000) begin
      if (cyc > 0) @(negedge clk);
      cyc++;
      start = (idx == start_at && start_at >= 0);
      if (gaps && $urandom_range(0, 1) == 0) begin
        in_valid = 1'b0;
        a = 8'hAA; b = 8'h55; o = 9'h1FF;
      end else begin
        in_valid = 1'b1;
        a = va[idx]; b = vb[idx]; o = vo[idx];
      end
      acc = in_valid && in_ready;
      @(posedge clk);
      if (acc) idx++;
    end
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b0;
    chk({tag, ".accepted"}, 64'(idx), 64'(N));
    chk({tag, ".ready_after_n"}, 64'(in_ready), 64'd0);
    chk({tag, ".busy_after_n"}, 64'(busy), 64'd1);
  endtask

  task automatic wait_done(input string tag);
    int cyc = 0;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, ".done"}, 64'(done), 64'd1);
    chk({tag, ".busy_done"}, 64'(busy), 64'd0);
  endtask

  task automatic load_exact();
    for (int i = 0; i < N; i++) begin
      va[i] = W'((i * 37) % 256);
      vb[i] = W'((i * 91 + 13) % 256);
      vo[i] = {1'b0, va[i]} + {1'b0, vb[i]};
    end
  endtask

  initial begin
    // reset state
    #12;
    chk("rst.n", 64'(n_samples), 64'd0);
    chk("rst.ready", 64'(in_ready), 64'd0);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.done", 64'(done), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; a = 8'd9; b = 8'd9; o = 9'd0;
    @(negedge clk);
    chk("idle.ready", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("idle.n", 64'(n_samples), 64'd0);

    // exact sums, with a start pulse mid-run that must be ignored
    load_exact();
    run_vectors("s1", 1'b0, 30);
    wait_done("s1");
    chk_stats("s1", N, 0, 0, 0, 0, 0, 0);

    // constant +3 error: ties keep the first sample's operands
    for (int i = 0; i < N; i++) begin
      va[i] = W'(i + 5);
      vb[i] = W'(i + 7);
      vo[i] = {1'b0, va[i]} + {1'b0, vb[i]} + 9'd3;
    end
    run_vectors("s2", 1'b0, -1);
    wait_done("s2");
    chk_stats("s2", N, N, 3 * N, 9 * N, 3, 5, 7);

    // corner errors among exact samples: +1, -1, -510
    load_exact();
    va[5]  = 8'd2;   vb[5]  = 8'd3;   vo[5]  = 9'd6;
    va[10] = 8'd1;   vb[10] = 8'd1;   vo[10] = 9'd1;
    va[20] = 8'd255; vb[20] = 8'd255; vo[20] = 9'd0;
    run_vectors("s3", 1'b0, -1);
    wait_done("s3");
    chk_stats("s3", N, 3, 512, 260102, 510, 255, 255);

    // same sequence with random valid gaps
    run_vectors("s4", 1'b1, -1);
    wait_done("s4");
    chk_stats("s4", N, 3, 512, 260102, 510, 255, 255);
    in_valid = 1'b1; a = 8'd200; b = 8'd100; o = 9'd0;
    repeat (5) @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("s4.done_ignores.n", 64'(n_samples), 64'(N));
    chk("s4.done_ignores.sabs", 64'(sum_abs), 64'd512);
    chk("s4.done_ready", 64'(in_ready), 64'd0);

    // async reset with samples in flight
    do_start();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; a = 8'(i); b = 8'd1; o = 9'(i + 2);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("s5.pre_rst.sabs", 64'(sum_abs), 64'd2);
    #2 rst = 1'b1;
    #1;
    chk("s5.rst.n", 64'(n_samples), 64'd0);
    chk("s5.rst.err", 64'(err_count), 64'd0);
    chk("s5.rst.sabs", 64'(sum_abs), 64'd0);
    chk("s5.rst.ssq", 64'(sum_sq), 64'd0);
    chk("s5.rst.wce", 64'(wce), 64'd0);
    chk("s5.rst.busy", 64'(busy), 64'd0);
    chk("s5.rst.ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("s5.idle.n", 64'(n_samples), 64'd0);
    chk("s5.idle.busy", 64'(busy), 64'd0);
    load_exact();
    run_vectors("s5", 1'b0, -1);
    wait_done("s5");
    chk_stats("s5", N, 0, 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
